// File: rtl/hex8_pkg.sv
// Shared constants and types for the hex8 core and its boot loader.
package hex8_pkg;

  localparam int HEX8_ADDR_W = 8;
  localparam int HEX8_DATA_W = 8;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_HOLD,
    S_RUN
  } loader_state_t;

endpackage

// File: rtl/hex8_loader.sv
// Boot loader: receives LEN / data / CSUM frames, writes the image into hex8
// memory and releases the core's reset once the checksum is good.
module hex8_loader
  import hex8_pkg::*;
#(
  parameter logic [HEX8_ADDR_W-1:0] LOAD_BASE  = 8'h00,
  parameter int                     RESET_HOLD = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [HEX8_DATA_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [HEX8_ADDR_W-1:0] mem_addr,
  output logic [HEX8_DATA_W-1:0] mem_wdata,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

  loader_state_t state, state_d;
  logic [8:0] cnt, cnt_d;
  logic [HEX8_ADDR_W-1:0] idx, idx_d;
  logic [HEX8_DATA_W-1:0] sum, sum_d, csum_total;
  logic [3:0] hold, hold_d;
  logic error_d, we_d;
  logic [HEX8_ADDR_W-1:0] addr_d;
  logic [HEX8_DATA_W-1:0] wdata_d;
  logic xfer;

  assign in_ready   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign xfer       = in_valid && in_ready;
  assign cpu_reset  = (state != S_RUN);
  assign done       = (state == S_RUN);
  assign csum_total = sum + in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LEN;
      cnt       <= '0;
      idx       <= '0;
      sum       <= '0;
      hold      <= '0;
      error     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      sum       <= sum_d;
      hold      <= hold_d;
      error     <= error_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  // The write port is registered: a data byte taken on this edge is written next cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sum_d   = sum;
    hold_d  = hold;
    error_d = error;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    case (state)
      S_LEN: begin
        if (xfer) begin
          cnt_d   = (in_data == '0) ? 9'd256 : {1'b0, in_data};
          sum_d   = '0;
          idx_d   = '0;
          error_d = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_d   = csum_total;
          idx_d   = idx + 8'd1;
          cnt_d   = cnt - 9'd1;
          we_d    = 1'b1;
          addr_d  = LOAD_BASE + idx;
          wdata_d = in_data;
          if (cnt == 9'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (csum_total == '0) begin
            hold_d  = 4'(RESET_HOLD);
            state_d = S_HOLD;
          end else begin
            error_d = 1'b1;
            state_d = S_LEN;
          end
        end
      end
      S_HOLD: begin
        hold_d = hold - 4'd1;
        if (hold == 4'd1) state_d = S_RUN;
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: state_d = S_LEN;
    endcase
  end

endmodule

// File: tb/tb_hex8_loader.sv
// Three loaders (base 00/hold 2, base F0/hold 2, base 00/hold 5) share one
// input stream; a queue of expected writes is compared against all three.
module tb_hex8_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_ready, mem_we, cpu_reset, done, error;
  logic [7:0] mem_addr  [3];
  logic [7:0] mem_wdata [3];

  localparam logic [7:0] BASE [3] = '{8'h00, 8'hF0, 8'h00};
  localparam int         HOLD [3] = '{2, 2, 5};

  int compared   = 0;
  int mismatched = 0;

  logic [47:0] exp_q [$];
  logic [47:0] mon_e;
  logic [7:0]  frame [$];

  int         m_state;
  int         m_cnt;
  logic [7:0] m_idx, m_sum;

  hex8_loader #(.LOAD_BASE(8'h00), .RESET_HOLD(2)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .cpu_reset(cpu_reset[0]), .done(done[0]), .error(error[0]));

  hex8_loader #(.LOAD_BASE(8'hF0), .RESET_HOLD(2)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .cpu_reset(cpu_reset[1]), .done(done[1]), .error(error[1]));

  hex8_loader #(.LOAD_BASE(8'h00), .RESET_HOLD(5)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .cpu_reset(cpu_reset[2]), .done(done[2]), .error(error[2]));

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mem_we != 3'b000) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {29'b0, mem_we}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("we_all", {29'b0, mem_we}, 32'h7);
        checkOutput("write_u0", {16'h0, mem_addr[0], mem_wdata[0]}, {16'h0, mon_e[47:32]});
        checkOutput("write_u1", {16'h0, mem_addr[1], mem_wdata[1]}, {16'h0, mon_e[31:16]});
        checkOutput("write_u2", {16'h0, mem_addr[2], mem_wdata[2]}, {16'h0, mon_e[15:0]});
      end
    end
  end

  task automatic checkRelease();
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("cpu_reset_u%0d_c0", k), {31'b0, cpu_reset[k]}, 32'h1);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        checkOutput($sformatf("cpu_reset_u%0d_c%0d", k, j), {31'b0, cpu_reset[k]},
                    (j < HOLD[k]) ? 32'h1 : 32'h0);
    end
    checkOutput("done_after_release", {29'b0, done}, 32'h7);
    checkOutput("error_after_release", {29'b0, error}, 32'h0);
    checkOutput("ready_after_release", {29'b0, in_ready}, 32'h0);
  endtask

  task automatic checkBad();
    checkOutput("error_bad", {29'b0, error}, 32'h7);
    checkOutput("cpu_reset_bad", {29'b0, cpu_reset}, 32'h7);
    checkOutput("ready_bad", {29'b0, in_ready}, 32'h7);
    checkOutput("done_bad", {29'b0, done}, 32'h0);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int   waited  = 0;
    bit   is_len  = 0;
    bit   is_data = 0;
    bit   is_csum = 0;
    bit   good    = 0;
    logic [7:0] a0, a1, a2;
    while (in_ready[0] !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready[0] !== 1'b1) begin
      checkOutput("ready_timeout", {29'b0, in_ready}, 32'h7);
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    case (m_state)
      0: begin
        is_len  = 1;
        m_cnt   = (b == 8'h00) ? 256 : int'(b);
        m_idx   = 8'h00;
        m_sum   = 8'h00;
        m_state = 1;
      end
      1: begin
        is_data = 1;
        a0 = BASE[0] + m_idx;
        a1 = BASE[1] + m_idx;
        a2 = BASE[2] + m_idx;
        exp_q.push_back({a0, b, a1, b, a2, b});
        m_sum = m_sum + b;
        m_idx = m_idx + 8'd1;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 2;
      end
      default: begin
        is_csum = 1;
        good    = (8'(m_sum + b) == 8'h00);
        m_state = good ? 3 : 0;
      end
    endcase
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    checkOutput("we_strobe", {29'b0, mem_we}, is_data ? 32'h7 : 32'h0);
    if (is_len) checkOutput("error_clear_on_len", {29'b0, error}, 32'h0);
    if (is_csum && good) checkRelease();
    else if (is_csum) checkBad();
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sendFrame(input int gap);
    foreach (frame[i]) applyStimulus(frame[i], gap);
  endtask

  task automatic doReset(input int cycles);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    checkOutput("rst_we", {29'b0, mem_we}, 32'h0);
    checkOutput("rst_cpu_reset", {29'b0, cpu_reset}, 32'h7);
    checkOutput("rst_done", {29'b0, done}, 32'h0);
    checkOutput("rst_error", {29'b0, error}, 32'h0);
    checkOutput("rst_ready", {29'b0, in_ready}, 32'h7);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_addr_u%0d", k), {24'h0, mem_addr[k]}, 32'h0);
      checkOutput($sformatf("rst_wdata_u%0d", k), {24'h0, mem_wdata[k]}, 32'h0);
    end
    checkOutput("pending_writes", exp_q.size(), 32'h0);
    exp_q.delete();
    m_state = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    m_state  = 0;
    doReset(2);

    $display("[TB] good frame");
    frame = '{8'h03, 8'hA5, 8'h12, 8'h00, 8'h49};
    sendFrame(0);
    doReset(1);

    $display("[TB] bad checksum then recovery frame");
    frame = '{8'h03, 8'hA5, 8'h12, 8'h00, 8'h48};
    sendFrame(0);
    frame = '{8'h01, 8'h7F, 8'h81};
    sendFrame(0);
    doReset(1);

    $display("[TB] 256-byte frame with address wrap");
    frame.delete();
    frame.push_back(8'h00);
    for (int i = 0; i < 256; i++) frame.push_back(8'(i));
    frame.push_back(8'h80);
    sendFrame(0);
    doReset(1);

    $display("[TB] gapped input");
    frame = '{8'h02, 8'h11, 8'h22, 8'hCD};
    sendFrame(3);
    doReset(1);

    $display("[TB] reset mid-frame");
    frame = '{8'h04, 8'h01, 8'h02};
    sendFrame(0);
    doReset(1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    frame = '{8'h01, 8'h05, 8'hFB};
    sendFrame(0);
    doReset(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
